qei_decoder: RTL and testbench
==============================

Name: qei_decoder

Overview:
- Quadrature encoder interface for one motor axis; sits directly downstream of the M*_ENC_A/B/Z pins and upstream of the servo controller inside the system interconnect.
- Synchronises and glitch-filters A/B/Z, then decodes 4x quadrature into a signed position count.
- Latches the count on index (Z) rising edge; flags illegal transitions.
- Exposes count, index latch, status and control through a 4-word Avalon-MM slave with read latency 1.

Parameters:
- CNT_W, 32, position/latch counter width (8..32).
- SYNC_STAGES, 2, synchroniser flops per encoder input (>=2).
- FILT_LEN, 4, consecutive stable samples required before a filtered input changes (1..255).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  reset; asynchronous assert, active-low.
- enc_a  in  1  raw encoder A, asynchronous.
- enc_b  in  1  raw encoder B, asynchronous.
- enc_z  in  1  raw encoder index, asynchronous.
- avs_address  in  2  register select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid the cycle after avs_read.
- count  out  CNT_W  live position, two's complement.
- index_irq  out  1  mirrors STATUS.index_seen.

Behaviour:
- Reset values: all flops 0 except CTRL=0x1; count=0; avs_readdata=0; index_irq=0; filtered A/B/Z=0; primed=0.
- Synchroniser: SYNC_STAGES flops per input.
- Filter, per channel: counter resets whenever the synced value equals the filtered value. Filtered value takes the synced value once it has differed for FILT_LEN consecutive clocks.
- Pin-to-filtered latency: SYNC_STAGES+FILT_LEN clocks. Pulses shorter than FILT_LEN clocks are rejected.
- Priming: primed sets once all three filter counters are 0 for FILT_LEN consecutive clocks after reset.
  - Before primed: the previous-state register tracks the filtered {A,B}.
  - Before primed: no count step, no error, no index latch.
- Decode compares filtered {A,B} against the previous state:
  - Forward (+1): 00->10->11->01->00.
  - Reverse (-1): the opposite order.
  - No change: 0.
  - Both bits change: count unchanged; STATUS.quad_err sets.
- CTRL.invert swaps the sign of each step.
- Count register updates 1 clock after the filtered change. Wraps modulo 2^CNT_W; no saturation.
- dir = sign of the last nonzero step (1 = forward). Holds its value when no step occurs.
- CTRL.enable=0: count frozen. Filtering, previous-state tracking, index latch and error detection continue, so re-enable causes no spurious step.
- Index: on a filtered Z 0->1 edge (primed), INDEX_LATCH <= count register value from the same cycle (pre-step), and index_seen sets.
- Registers (32-bit; CNT_W values sign-extended on read):
  - 0 COUNT: R = count. W = load writedata[CNT_W-1:0].
  - 1 INDEX_LATCH: R only; writes ignored.
  - 2 STATUS: R = {26'b0, z_f, b_f, a_f, quad_err, index_seen, dir}. W = write-1-to-clear bits 2:1.
  - 3 CTRL: R/W; bit0 = enable, bit1 = invert, other bits read 0.
- Simultaneous events:
  - COUNT write and step in the same cycle: write wins, step is dropped.
  - Clear and set of a sticky bit in the same cycle: set wins.
  - Index latch and COUNT write in the same cycle: latch takes the pre-write value.
- avs_read and avs_write in the same cycle: both take effect; read returns the pre-write value.
- Reset mid-operation: asynchronous clear of everything; priming restarts.

Optional Feature:
- Macro: QEI_INDEX_ZERO_EN.
- Defined: adds CTRL bit2 index_zero (reset 0). When set, a primed Z rising edge also loads count <= 0 in the same cycle as the latch. Precedence: COUNT write > index zero > step.
- Undefined: CTRL bit2 reads 0 and writes are ignored; Z never modifies count.

Test Plan:
- Reset, FILT_LEN=4, pins held A=B=1 -> primed after settling; count=0; quad_err=0.
- 8 forward cycles (32 edges, 20 clk/edge) -> count=32, dir=1. Then 3 reverse edges -> count=29, dir=0.
- 3-clk glitch on A -> count unchanged. 4-clk pulse -> filtered A toggles and count steps.
- Force A and B to change in the same clock -> quad_err=1, count unchanged. Write STATUS=0x4 -> quad_err=0.
- Count at 0x7FFFFFFF plus one forward edge -> 0x80000000. Write COUNT=5 in the same cycle as a step -> count=5.
- Z edge at count=100 -> INDEX_LATCH=100, index_irq=1. With QEI_INDEX_ZERO_EN defined and index_zero=1 -> count=0 the next clock.

Source files
------------

// File: rtl/qei_decoder.sv
// qei_decoder: quadrature encoder interface: sync + glitch filter, 4x decode,
// index latch, Avalon-MM slave. Optional index-zero feature: QEI_INDEX_ZERO_EN.
//
// state  | meaning
// SETTLE | after reset; prev-state tracks filtered inputs, no steps/errors/index
// RUN    | primed; steps, quad errors and index edges are acted on
module qei_decoder #(
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             enc_z,
   input  logic [1:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic [CNT_W-1:0] count,
   output logic             index_irq
);

   localparam int            FW        = 8;
   localparam logic [FW-1:0] FILT_LOAD = FW'(FILT_LEN - 1);

   localparam logic [1:0] ADDR_COUNT  = 2'd0;
   localparam logic [1:0] ADDR_LATCH  = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

`ifdef QEI_INDEX_ZERO_EN
   localparam logic [2:0] CTRL_MASK = 3'b111;
`else
   localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [FW-1:0] settle_q, settle_d;
   logic          primed;

   logic [2:0]    sync_q [SYNC_STAGES];
   logic [2:0]    synced;
   logic [2:0]    filt_q;
   logic [FW-1:0] filt_cnt [3];
   logic [2:0]    idle;

   logic [1:0]       prev_ab_q;
   logic             z_prev_q;
   logic [1:0]       ab_f;
   logic [1:0]       pos_diff;
   logic             step_fwd, step_rev, step_inc, step_dec;
   logic             quad_err_set, z_rise;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] latch_q;
   logic             dir_q;
   logic             quad_err_q;
   logic             index_seen_q;
   logic [2:0]       ctrl_q;
   logic             enable, invert;

   logic             wr_count, wr_status, wr_ctrl;
   logic [31:0]      count_ext, latch_ext, rd_mux;

   // Channel order in all 3-bit vectors: {z, b, a}
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {enc_z, enc_b, enc_a};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Down-counter per channel, reloaded while input agrees with the filtered value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= '0;
         for (int c = 0; c < 3; c++) filt_cnt[c] <= '0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (synced[c] == filt_q[c]) begin
               filt_cnt[c] <= FILT_LOAD;
            end else if (filt_cnt[c] == '0) begin
               filt_q[c]   <= synced[c];
               filt_cnt[c] <= FILT_LOAD;
            end else begin
               filt_cnt[c] <= filt_cnt[c] - 1'b1;
            end
         end
      end
   end

   assign idle = synced ~^ filt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_SETTLE;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         ST_SETTLE: begin
            if (idle != 3'b111)          settle_d = '0;
            else if (settle_q == FILT_LOAD) state_d = ST_RUN;
            else                         settle_d = settle_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign primed = (state_q == ST_RUN);

   // Gray-coded {A,B} to position around the cycle 00 -> 10 -> 11 -> 01
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   gray_pos = 2'd0;
         2'b10:   gray_pos = 2'd1;
         2'b11:   gray_pos = 2'd2;
         default: gray_pos = 2'd3;
      endcase
   endfunction

   assign ab_f     = {filt_q[0], filt_q[1]};
   assign pos_diff = gray_pos(ab_f) - gray_pos(prev_ab_q);
   assign enable   = ctrl_q[0];
   assign invert   = ctrl_q[1];

   assign step_fwd     = primed && (pos_diff == 2'd1);
   assign step_rev     = primed && (pos_diff == 2'd3);
   assign quad_err_set = primed && (pos_diff == 2'd2);
   assign step_inc     = invert ? step_rev : step_fwd;
   assign step_dec     = invert ? step_fwd : step_rev;
   assign z_rise       = primed && filt_q[2] && !z_prev_q;

   assign wr_count  = avs_write && (avs_address == ADDR_COUNT);
   assign wr_status = avs_write && (avs_address == ADDR_STATUS);
   assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);

   // Previous state follows the filtered inputs in every state and enable setting
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_ab_q <= '0;
         z_prev_q  <= 1'b0;
      end else begin
         prev_ab_q <= ab_f;
         z_prev_q  <= filt_q[2];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (wr_count) begin
         count_q <= avs_writedata[CNT_W-1:0];
`ifdef QEI_INDEX_ZERO_EN
      end else if (z_rise && ctrl_q[2]) begin
         count_q <= '0;
`endif
      end else if (enable && step_inc) begin
         count_q <= count_q + CNT_W'(1);
      end else if (enable && step_dec) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir_q        <= 1'b0;
         latch_q      <= '0;
         quad_err_q   <= 1'b0;
         index_seen_q <= 1'b0;
         ctrl_q       <= 3'b001;
      end else begin
         if (enable && step_inc)      dir_q <= 1'b1;
         else if (enable && step_dec) dir_q <= 1'b0;

         if (z_rise) latch_q <= count_q;

         if (quad_err_set)                     quad_err_q <= 1'b1;
         else if (wr_status && avs_writedata[2]) quad_err_q <= 1'b0;

         if (z_rise)                             index_seen_q <= 1'b1;
         else if (wr_status && avs_writedata[1]) index_seen_q <= 1'b0;

         if (wr_ctrl) ctrl_q <= avs_writedata[2:0] & CTRL_MASK;
      end
   end

   assign count_ext = 32'(signed'(count_q));
   assign latch_ext = 32'(signed'(latch_q));

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         ADDR_COUNT:  rd_mux = count_ext;
         ADDR_LATCH:  rd_mux = latch_ext;
         ADDR_STATUS: rd_mux = {26'b0, filt_q[2], filt_q[1], filt_q[0],
                                quad_err_q, index_seen_q, dir_q};
         ADDR_CTRL:   rd_mux = {29'b0, ctrl_q};
         default:     rd_mux = '0;
      endcase
   end

   // Read data samples pre-write state, so a same-cycle write is not visible
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      avs_readdata <= '0;
      else if (avs_read) avs_readdata <= rd_mux;
   end

   assign count     = count_q;
   assign index_irq = index_seen_q;

endmodule

// File: tb/tb_qei_decoder.sv
// tb_qei_decoder: directed + randomized checks of qei_decoder against a
// position/phase model of the encoder (phase walk around the quadrature cycle).
module tb_qei_decoder;

   localparam int CNT_W = 32;
   localparam int SYNC  = 2;
   localparam int FILT  = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enc_a, enc_b, enc_z;
   logic [1:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic [CNT_W-1:0] count;
   logic        index_irq;

   qei_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enc_a         (enc_a),
      .enc_b         (enc_b),
      .enc_z         (enc_z),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .count         (count),
      .index_irq     (index_irq)
   );

   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // model: encoder phase 0..3 around 00 -> 10 -> 11 -> 01, expected count and flags
   int          phase;
   logic [31:0] m_count;
   logic        m_dir;
   logic        m_en;
   logic        m_inv;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] ab_of(input int p);
      logic [1:0] tbl [4];
      tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b11; tbl[3] = 2'b01;
      return tbl[p & 3];
   endfunction

   function automatic int phase_of(input logic [1:0] ab);
      for (int p = 0; p < 4; p++) if (ab_of(p) == ab) return p;
      return 0;
   endfunction

   task automatic drive_phase(input int p);
      {enc_a, enc_b} = ab_of(p);
   endtask

   // one encoder edge in direction d (+1/-1), then hold the new level
   task automatic move(input int d, input int hold);
      int s;
      @(negedge clk);
      phase = (phase + d) & 3;
      drive_phase(phase);
      if (m_en) begin
         s = m_inv ? -d : d;
         m_count = m_count + 32'(s);
         m_dir = (s > 0);
      end
      repeat (hold) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_address = a; avs_read = 1'b1;
      @(negedge clk);
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic bus_rw(input logic [1:0] a, input logic [31:0] wd, output logic [31:0] rd);
      @(negedge clk);
      avs_address = a; avs_writedata = wd; avs_read = 1'b1; avs_write = 1'b1;
      @(negedge clk);
      avs_read = 1'b0; avs_write = 1'b0;
      rd = avs_readdata;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          d, np, base;

      reset_n = 1'b0;
      avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
      phase = 2; drive_phase(phase); enc_z = 1'b0;
      m_count = '0; m_dir = 1'b0; m_en = 1'b1; m_inv = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_count", count, 32'h0);
      check("rst_readdata", avs_readdata, 32'h0);
      check("rst_irq", {31'b0, index_irq}, 32'h0);
      reset_n = 1'b1;

      // priming with A=B=1 held through reset: no spurious step
      repeat (20) @(negedge clk);
      bus_rd(2'd3, rd);
      check("ctrl_reset", rd, 32'h1);
      bus_rd(2'd2, rd);
      check("status_primed", rd, 32'h18);
      check("count_primed", count, 32'h0);

      // 8 forward cycles then 3 reverse edges
      for (int i = 0; i < 32; i++) begin
         move(1, 20);
         if ((i % 8) == 7) check("fwd_count", count, m_count);
      end
      check("fwd_32", count, 32'd32);
      bus_rd(2'd2, rd);
      check("fwd_dir", {31'b0, rd[0]}, {31'b0, m_dir});
      for (int i = 0; i < 3; i++) move(-1, 20);
      check("rev_29", count, 32'd29);
      bus_rd(2'd2, rd);
      check("rev_dir", {31'b0, rd[0]}, 32'h0);

      // glitch on A: 3 clocks rejected, 4 clocks accepted
      np = phase_of({~enc_a, enc_b});
      d  = (((np - phase) & 3) == 1) ? 1 : -1;
      base = 29;
      @(negedge clk); enc_a = ~enc_a;
      repeat (3) @(negedge clk); enc_a = ~enc_a;
      repeat (20) @(negedge clk);
      check("glitch3", count, 32'(base));
      @(negedge clk); enc_a = ~enc_a;
      repeat (4) @(negedge clk); enc_a = ~enc_a;
      repeat (4) @(negedge clk);
      check("pulse4_step", count, 32'(base + d));
      repeat (10) @(negedge clk);
      check("pulse4_back", count, 32'(base));

      // both bits change in one clock
      @(negedge clk);
      phase = (phase + 2) & 3;
      drive_phase(phase);
      repeat (20) @(negedge clk);
      check("qerr_count", count, m_count);
      bus_rd(2'd2, rd);
      check("qerr_set", {31'b0, rd[2]}, 32'h1);
      bus_wr(2'd2, 32'h4);
      bus_rd(2'd2, rd);
      check("qerr_clr", {31'b0, rd[2]}, 32'h0);

      // read and write same cycle, then wrap
      bus_rw(2'd0, 32'h7FFF_FFFF, rd);
      check("rw_pre_value", rd, m_count);
      m_count = 32'h7FFF_FFFF;
      check("load_max", count, m_count);
      move(1, 20);
      check("wrap", count, 32'h8000_0000);

      // COUNT write lands on the same clock as a step
      @(negedge clk);
      phase = (phase + 1) & 3;
      drive_phase(phase);
      repeat (SYNC + FILT) @(negedge clk);
      avs_address = 2'd0; avs_writedata = 32'd5; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
      check("wr_vs_step", count, 32'd5);
      repeat (20) @(negedge clk);
      check("wr_vs_step_hold", count, 32'd5);
      m_count = 32'd5;

      // index latch
      bus_wr(2'd0, 32'd100);
      m_count = 32'd100;
      @(negedge clk); enc_z = 1'b1;
      repeat (12) @(negedge clk);
      check("index_irq", {31'b0, index_irq}, 32'h1);
      bus_rd(2'd1, rd);
      check("index_latch", rd, 32'd100);
      check("index_count", count, m_count);
      bus_wr(2'd1, 32'd55);
      bus_rd(2'd1, rd);
      check("latch_ro", rd, 32'd100);
      bus_wr(2'd2, 32'h2);
      check("index_clr", {31'b0, index_irq}, 32'h0);
      @(negedge clk); enc_z = 1'b0;
      repeat (12) @(negedge clk);

`ifdef QEI_INDEX_ZERO_EN
      bus_wr(2'd3, 32'h5);
      bus_rd(2'd3, rd);
      check("ctrl_iz", rd, 32'h5);
      bus_wr(2'd0, 32'd77);
      @(negedge clk); enc_z = 1'b1;
      repeat (12) @(negedge clk);
      check("index_zero", count, 32'h0);
      bus_rd(2'd1, rd);
      check("index_zero_latch", rd, 32'd77);
      m_count = 32'h0;
      @(negedge clk); enc_z = 1'b0;
      repeat (12) @(negedge clk);
      bus_wr(2'd3, 32'h1);
      bus_wr(2'd2, 32'h2);
`else
      bus_wr(2'd3, 32'h7);
      bus_rd(2'd3, rd);
      check("ctrl_bit2_ro", rd, 32'h3);
      bus_wr(2'd3, 32'h1);
`endif

      // randomized walk with enable/invert changes and COUNT loads
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0: begin
               m_en  = 1'($urandom_range(0, 1));
               m_inv = 1'($urandom_range(0, 1));
               bus_wr(2'd3, {30'b0, m_inv, m_en});
            end
            1: begin
               m_count = $urandom;
               bus_wr(2'd0, m_count);
            end
            default: move($urandom_range(0, 1) ? 1 : -1, $urandom_range(8, 25));
         endcase
         check("rand_count", count, m_count);
      end
      bus_rd(2'd2, rd);
      check("rand_filt", {29'b0, rd[5:3]}, {29'b0, enc_z, enc_b, enc_a});
      check("rand_qerr", {31'b0, rd[2]}, 32'h0);

      // asynchronous reset mid-operation, then re-prime on a nonzero phase
      @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("midrst_count", count, 32'h0);
      check("midrst_irq", {31'b0, index_irq}, 32'h0);
      m_count = '0; m_en = 1'b1; m_inv = 1'b0;
      @(negedge clk);
      phase = 1; drive_phase(phase);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      check("reprime_count", count, 32'h0);
      bus_rd(2'd3, rd);
      check("reprime_ctrl", rd, 32'h1);
      move(1, 20);
      check("reprime_step", count, m_count);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
